// File: rtl/simmem_release_scheduler.sv
// Round-robin release scheduler: picks one expired entry per cycle and hands its
// address to the bank over valid/ready. Optional counters under SIMMEM_RELEASE_STATS_EN.
module simmem_release_scheduler #(
    parameter int Capacity  = 16,
    parameter int AddrWidth = $clog2(Capacity)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [Capacity-1:0]  release_en_onehot_i,
    output logic                 release_valid_o,
    output logic [AddrWidth-1:0] release_addr_o,
    input  logic                 release_ready_i,
`ifdef SIMMEM_RELEASE_STATS_EN
    output logic [Capacity-1:0]  released_addr_onehot_o,
    output logic [31:0]          release_cnt_o,
    output logic [31:0]          stall_cnt_o
`else
    output logic [Capacity-1:0]  released_addr_onehot_o
`endif
);

    typedef enum logic {IDLE, HOLD} state_e;

    localparam logic [Capacity-1:0] OneLsb = Capacity'(1);
    localparam logic [AddrWidth:0]  CapW   = (AddrWidth+1)'(Capacity);
    localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(Capacity - 1);

    state_e               state_q;
    logic                 valid_q;
    logic [AddrWidth-1:0] addr_q, ptr_q, ptr_next, sel_addr, pe_idx;
    logic [Capacity-1:0]  held_mask, eligible, rotated;
    logic                 any_eligible, handshake;

    // Modular add; both operands are < Capacity so one subtraction suffices.
    function automatic logic [AddrWidth-1:0] wrap_add(input logic [AddrWidth-1:0] a,
                                                      input logic [AddrWidth-1:0] b);
        logic [AddrWidth:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= CapW) s = s - CapW;
        return s[AddrWidth-1:0];
    endfunction

    assign handshake              = valid_q && release_ready_i;
    assign held_mask              = valid_q ? (OneLsb << addr_q) : '0;
    assign eligible               = release_en_onehot_i & ~held_mask;
    assign released_addr_onehot_o = handshake ? (OneLsb << addr_q) : '0;
    assign ptr_next               = (addr_q == LastIdx) ? '0 : addr_q + AddrWidth'(1);

    // Rotate so ptr_q lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rotated      = '0;
        pe_idx       = '0;
        any_eligible = 1'b0;
        for (int i = 0; i < Capacity; i++) begin
            rotated[i] = eligible[wrap_add(AddrWidth'(i), ptr_q)];
        end
        for (int i = Capacity - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                pe_idx       = AddrWidth'(i);
                any_eligible = 1'b1;
            end
        end
        sel_addr = wrap_add(pe_idx, ptr_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_eligible) begin
                        addr_q  <= sel_addr;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // Never retract: the held address waits for the bank even if its enable drops.
                    if (handshake) begin
                        ptr_q <= ptr_next;
                        if (any_eligible) begin
                            addr_q <= sel_addr;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign release_valid_o = valid_q;
    assign release_addr_o  = addr_q;

`ifdef SIMMEM_RELEASE_STATS_EN
    logic [31:0] release_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            release_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if (handshake && (release_cnt_q != '1)) release_cnt_q <= release_cnt_q + 32'd1;
            if (valid_q && !release_ready_i && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign release_cnt_o = release_cnt_q;
    assign stall_cnt_o   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Directed bench for simmem_release_scheduler: Capacity=16 and Capacity=12 instances.
module tb_simmem_release_scheduler;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;

    logic [15:0] en16 = '0;
    logic        rdy16 = 1'b0;
    logic        v16;
    logic [3:0]  a16;
    logic [15:0] oh16;

    logic [11:0] en12 = '0;
    logic        rdy12 = 1'b0;
    logic        v12;
    logic [3:0]  a12;
    logic [11:0] oh12;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

`ifdef SIMMEM_RELEASE_STATS_EN
    logic [31:0] rc16, sc16, rc12, sc12;
`endif

    simmem_release_scheduler #(.Capacity(16)) dut16 (
        .clk_i                  (clk),
        .rst_ni                 (rst_ni),
        .release_en_onehot_i    (en16),
        .release_valid_o        (v16),
        .release_addr_o         (a16),
        .release_ready_i        (rdy16),
`ifdef SIMMEM_RELEASE_STATS_EN
        .released_addr_onehot_o (oh16),
        .release_cnt_o          (rc16),
        .stall_cnt_o            (sc16)
`else
        .released_addr_onehot_o (oh16)
`endif
    );

    simmem_release_scheduler #(.Capacity(12)) dut12 (
        .clk_i                  (clk),
        .rst_ni                 (rst_ni),
        .release_en_onehot_i    (en12),
        .release_valid_o        (v12),
        .release_addr_o         (a12),
        .release_ready_i        (rdy12),
`ifdef SIMMEM_RELEASE_STATS_EN
        .released_addr_onehot_o (oh12),
        .release_cnt_o          (rc12),
        .stall_cnt_o            (sc12)
`else
        .released_addr_onehot_o (oh12)
`endif
    );

    typedef struct {
        logic [15:0] en;
        logic        rdy;
        logic        v;
        logic [3:0]  a;
        logic [15:0] oh;
    } vec_t;

    vec_t t16[16];
    vec_t t12[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        // single request, backpressure on addr 7, simultaneous rise during addr 3 release
        t16[0]  = '{16'h0010, 1'b1, 1'b0, 4'd0,  16'h0000};
        t16[1]  = '{16'h0010, 1'b1, 1'b1, 4'd4,  16'h0010};
        t16[2]  = '{16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000};
        t16[3]  = '{16'h0080, 1'b0, 1'b0, 4'd0,  16'h0000};
        for (int i = 4; i <= 8; i++) t16[i] = '{16'h0100, 1'b0, 1'b1, 4'd7, 16'h0000};
        t16[9]  = '{16'h0100, 1'b1, 1'b1, 4'd7,  16'h0080};
        t16[10] = '{16'h0100, 1'b1, 1'b1, 4'd8,  16'h0100};
        t16[11] = '{16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000};
        t16[12] = '{16'h0008, 1'b0, 1'b0, 4'd0,  16'h0000};
        t16[13] = '{16'h0208, 1'b1, 1'b1, 4'd3,  16'h0008};
        t16[14] = '{16'h0200, 1'b1, 1'b1, 4'd9,  16'h0200};
        t16[15] = '{16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000};

        // Capacity=12: release 10 to park ptr at 11, then 11 -> 0 wrap
        t12[0] = '{16'h0400, 1'b1, 1'b0, 4'd0,  16'h0000};
        t12[1] = '{16'h0400, 1'b1, 1'b1, 4'd10, 16'h0400};
        t12[2] = '{16'h0801, 1'b1, 1'b0, 4'd0,  16'h0000};
        t12[3] = '{16'h0801, 1'b1, 1'b1, 4'd11, 16'h0800};
        t12[4] = '{16'h0001, 1'b1, 1'b1, 4'd0,  16'h0001};
        t12[5] = '{16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000};

        #2;
        chk("reset v16",  32'(v16),  32'd0);
        chk("reset a16",  32'(a16),  32'd0);
        chk("reset oh16", 32'(oh16), 32'd0);
        chk("reset v12",  32'(v12),  32'd0);
`ifdef SIMMEM_RELEASE_STATS_EN
        chk("reset rc16", rc16, 32'd0);
        chk("reset sc16", sc16, 32'd0);
`endif
        @(negedge clk);
        rst_ni = 1'b1;

        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            en16 = t16[r].en;
            rdy16 = t16[r].rdy;
            #1;
            chk($sformatf("t16[%0d].valid", r), 32'(v16), 32'(t16[r].v));
            chk($sformatf("t16[%0d].onehot", r), 32'(oh16), 32'(t16[r].oh));
            if (t16[r].v) chk($sformatf("t16[%0d].addr", r), 32'(a16), 32'(t16[r].a));
        end
`ifdef SIMMEM_RELEASE_STATS_EN
        chk("stall_cnt16", sc16, 32'd5);
        chk("release_cnt16", rc16, 32'd5);
`endif

        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            en12 = t12[r].en[11:0];
            rdy12 = t12[r].rdy;
            #1;
            chk($sformatf("t12[%0d].valid", r), 32'(v12), 32'(t12[r].v));
            chk($sformatf("t12[%0d].onehot", r), 32'(oh12), 32'(t12[r].oh));
            if (t12[r].v) chk($sformatf("t12[%0d].addr", r), 32'(a12), 32'(t12[r].a));
        end

        // Reset mid-HOLD: ptr is 10, so entry 5 is found after wrapping
        @(negedge clk);
        en16 = 16'h0020;
        rdy16 = 1'b0;
        @(negedge clk);
        #1;
        chk("pre-reset valid", 32'(v16), 32'd1);
        chk("pre-reset addr",  32'(a16), 32'd5);
        rst_ni = 1'b0;
        #1;
        chk("mid-hold reset valid", 32'(v16), 32'd0);
        chk("mid-hold reset addr",  32'(a16), 32'd0);
        chk("mid-hold reset ptr",   32'(dut16.ptr_q), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        #1;
        chk("post-reset valid", 32'(v16), 32'd1);
        chk("post-reset addr",  32'(a16), 32'd5);

        // Clean reset for the round-robin sweep from ptr 0
        rst_ni = 1'b0;
        en16 = '0;
        @(negedge clk);
        rst_ni = 1'b1;
        en16 = 16'hFFFF;
        rdy16 = 1'b1;
        #1;
        chk("rr idle", 32'(v16), 32'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 15) en16 = en16 | 16'h0001;
            #1;
            chk($sformatf("rr[%0d].valid", k), 32'(v16), 32'd1);
            chk($sformatf("rr[%0d].addr", k), 32'(a16), 32'(k));
            chk($sformatf("rr[%0d].onehot", k), 32'(oh16), 32'(16'h0001 << k));
            en16 = en16 & ~(16'h0001 << k);
        end
        @(negedge clk);
        #1;
        chk("rr wrap valid",  32'(v16),  32'd1);
        chk("rr wrap addr",   32'(a16),  32'd0);
        chk("rr wrap onehot", 32'(oh16), 32'h0001);
        en16 = '0;
        @(negedge clk);
        #1;
        chk("rr drain valid", 32'(v16), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
